// File: rtl/capture_pkg.sv
// Shared types and default sizing for the capture sequencer.
package capture_pkg;

    // The capture sequence: collect pre-trigger history, wait for the
    // trigger, collect post-trigger samples, then hold the result.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } capt_state_t;

    localparam int DEF_ENTRIES = 384;
    localparam int DEF_ADDR_W  = 9;

endpackage

// File: rtl/circ_addr_cnt.sv
// Circular address counter that wraps from ENTRIES-1 back to 0.
// prev_addr is the most recently passed address (the one just written
// when the counter advances once per write).
module circ_addr_cnt
    import capture_pkg::*;
#(
    parameter int ENTRIES = DEF_ENTRIES,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] prev_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ENTRIES - 1);

    logic [ADDR_W-1:0] r_addr;

    // Advance by one per increment request, wrapping at the last entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
        end else if (inc) begin
            r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
        end
    end

    assign addr      = r_addr;
    assign prev_addr = (r_addr == '0) ? LAST_ADDR : r_addr - 1'b1;

endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer: writes decimated samples into the circular sample
// RAM, arms the trigger units once enough pre-trigger history exists,
// counts the post-trigger samples and reports the final write address.
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int ENTRIES = DEF_ENTRIES,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              wrt_smpl,
    input  logic              triggered,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic              clr_done,
    output logic              armed,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              capture_done,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] TP_MAX      = ADDR_W'(ENTRIES - 1);
    localparam logic [ADDR_W:0]   ENTRIES_CNT = (ADDR_W + 1)'(ENTRIES);

    capt_state_t       r_state, w_state_next;
    logic [ADDR_W:0]   r_smpl_cnt, w_smpl_cnt_next, w_smpl_inc, w_arm_sum;
    logic [ADDR_W-1:0] r_post_cnt, w_post_cnt_next, w_post_inc;
    logic [ADDR_W-1:0] r_tp, w_tp_next, w_tp_clamped;
    logic [ADDR_W-1:0] r_trig_addr, w_trig_addr_next;
    logic              r_capture_done, w_capture_done_next;
    logic              r_armed, w_armed_next;
    logic              w_finish, w_busy, w_we;
    logic [ADDR_W-1:0] w_waddr, w_prev_addr;

    assign w_busy = (r_state == FILL) || (r_state == ARMED) || (r_state == POST);
    assign w_we   = wrt_smpl && w_busy;

    // A post count beyond the RAM depth could overwrite the trigger point.
    assign w_tp_clamped = (trig_pos > TP_MAX) ? TP_MAX : trig_pos;

    // History count saturates at ENTRIES; the sum below cannot overflow
    // ADDR_W+1 bits since both terms are at most ENTRIES.
    assign w_smpl_inc = (r_smpl_cnt == ENTRIES_CNT) ? r_smpl_cnt : r_smpl_cnt + 1'b1;
    assign w_arm_sum  = w_smpl_inc + {1'b0, r_tp};
    assign w_post_inc = r_post_cnt + 1'b1;

    circ_addr_cnt #(
        .ENTRIES (ENTRIES),
        .ADDR_W  (ADDR_W)
    ) u_waddr (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (w_we),
        .addr      (w_waddr),
        .prev_addr (w_prev_addr)
    );

    // Next-state and next-value logic for the capture sequence.
    always_comb begin
        w_state_next        = r_state;
        w_smpl_cnt_next     = r_smpl_cnt;
        w_post_cnt_next     = r_post_cnt;
        w_tp_next           = r_tp;
        w_trig_addr_next    = r_trig_addr;
        w_capture_done_next = r_capture_done;
        w_finish            = 1'b0;

        case (r_state)
            IDLE: begin
                if (run && !r_capture_done) begin
                    w_state_next    = FILL;
                    w_smpl_cnt_next = '0;
                    w_post_cnt_next = '0;
                    w_tp_next       = w_tp_clamped;
                end
            end
            FILL: begin
                if (wrt_smpl) begin
                    w_smpl_cnt_next = w_smpl_inc;
                    if (w_arm_sum >= ENTRIES_CNT) begin
                        w_state_next = ARMED;
                    end
                end
            end
            ARMED: begin
                if (triggered) begin
                    if (r_tp == '0) begin
                        w_finish = 1'b1;
                    end else begin
                        w_state_next = POST;
                    end
                end
            end
            POST: begin
                if (wrt_smpl) begin
                    w_post_cnt_next = w_post_inc;
                    if (w_post_inc == r_tp) begin
                        w_finish = 1'b1;
                    end
                end
            end
            DONE: begin
                // A run arriving together with the clear is dropped.
                if (clr_done) begin
                    w_state_next        = IDLE;
                    w_capture_done_next = 1'b0;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // The last sample is the one being written now, or the one
        // written before if this cycle carries no strobe.
        if (w_finish) begin
            w_state_next        = DONE;
            w_capture_done_next = 1'b1;
            w_trig_addr_next    = w_we ? w_waddr : w_prev_addr;
        end

        w_armed_next = (w_state_next == ARMED) || (w_state_next == POST);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Counters, latched post count and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_smpl_cnt     <= '0;
            r_post_cnt     <= '0;
            r_tp           <= '0;
            r_trig_addr    <= '0;
            r_capture_done <= 1'b0;
            r_armed        <= 1'b0;
        end else begin
            r_smpl_cnt     <= w_smpl_cnt_next;
            r_post_cnt     <= w_post_cnt_next;
            r_tp           <= w_tp_next;
            r_trig_addr    <= w_trig_addr_next;
            r_capture_done <= w_capture_done_next;
            r_armed        <= w_armed_next;
        end
    end

    assign armed        = r_armed;
    assign we           = w_we;
    assign waddr        = w_waddr;
    assign trig_addr    = r_trig_addr;
    assign capture_done = r_capture_done;
    assign busy         = w_busy;

endmodule
